pwd_mem_arbiter: RTL and testbench

- Shares the single-port 16-bit password RAM between two requesters:
  - Requester 0 is the admin/loader path.
  - Requester 1 is the user access-control FSM.
- Round-robin arbitration serialises one read or write at a time.
- Applies the RAM read latency and returns data with a one-cycle acknowledge.
- Write-protects a low address range against requester 1.

---
 rtl/pwd_mem_arbiter.sv | 116 +++++++++++
 tb/tb_pwd_mem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pwd_mem_arbiter.sv
// pwd_mem_arbiter: round-robin arbiter sharing the password RAM between loader and user FSM
module pwd_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int PROT_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              win, win_n, l_we, l_we_n, rej, rej_n, last_grant, last_grant_n, g;
  logic [1:0]        ack_n;
  logic              err_n, busy_n, mem_wren_n;
  logic [DATA_W-1:0] rdata_n, mem_data_n, g_wdata;
  logic [ADDR_W-1:0] mem_addr_n, g_addr;
  // next state and next registered outputs; RAM controls are set one edge early so they appear in ISSUE
  always_comb begin
    g = &req ? ~last_grant : req[1];
    g_addr = g ? addr1 : addr0;
    g_wdata = g ? wdata1 : wdata0;
    state_n = state;
    cnt_n = cnt;
    win_n = win;
    l_we_n = l_we;
    rej_n = rej;
    last_grant_n = last_grant;
    ack_n = '0;
    err_n = 1'b0;
    rdata_n = rdata;
    mem_addr_n = mem_addr;
    mem_wren_n = 1'b0;
    mem_data_n = mem_data;
    case (state)
      IDLE: if (|req) begin
        state_n = ISSUE;
        win_n = g;
        l_we_n = we[g];
        rej_n = g & we[g] & (addr1 < ADDR_W'(PROT_LIMIT));
        mem_addr_n = g_addr;
        mem_wren_n = we[g] & ~rej_n;
        mem_data_n = mem_wren_n ? g_wdata : mem_data;
      end
      ISSUE: if (l_we) begin
        state_n = DONE;
        ack_n[win] = 1'b1;
        err_n = rej;
      end else begin
        state_n = WAIT;
        cnt_n = CW'(RD_LAT - 1);
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          state_n = DONE;
          rdata_n = mem_q;
          ack_n[win] = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        last_grant_n = win;
      end
    endcase
    busy_n = state_n != IDLE;
  end
  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      win <= 1'b0;
      l_we <= 1'b0;
      rej <= 1'b0;
      last_grant <= 1'b1;
      ack <= '0;
      err <= 1'b0;
      rdata <= '0;
      busy <= 1'b0;
      mem_addr <= '0;
      mem_wren <= 1'b0;
      mem_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      win <= win_n;
      l_we <= l_we_n;
      rej <= rej_n;
      last_grant <= last_grant_n;
      ack <= ack_n;
      err <= err_n;
      rdata <= rdata_n;
      busy <= busy_n;
      mem_addr <= mem_addr_n;
      mem_wren <= mem_wren_n;
      mem_data <= mem_data_n;
    end
  end
endmodule

// File: tb/tb_pwd_mem_arbiter.sv
// tb_pwd_mem_arbiter: directed vector bench for the password RAM arbiter
module tb_pwd_mem_arbiter;
  logic        clk = 0, rst = 1;
  logic [1:0]  req = 0, we = 0, ack;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        err, busy, mem_wren;
  logic [15:0] rdata, mem_addr, mem_data, mem_q;
  logic [15:0] ram [16];
  logic [15:0] q0, q1;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        e_err;
    logic [15:0] e_rdata;
  } vec_t;
  vec_t v [10];

  pwd_mem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[3:0]] <= mem_data;
    q0 <= ram[mem_addr[3:0]];
    q1 <= q0;
  end
  assign mem_q = q1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t t);
    int lat;
    logic wren_exp;
    lat = t.w ? 2 : 4;
    wren_exp = t.w & ~t.e_err;
    req = 2'b00;
    req[t.r] = 1'b1;
    we[t.r] = t.w;
    we[~t.r] = ~t.w;
    addr0 = t.r ? t.a ^ 16'h8 : t.a;
    addr1 = t.r ? t.a : t.a ^ 16'h8;
    wdata0 = t.r ? ~t.d : t.d;
    wdata1 = t.r ? t.d : ~t.d;
    for (int c = 1; c <= lat; c++) begin
      step();
      chk("mem_wren", mem_wren, (c == 1) ? wren_exp : 1'b0);
      if (c == 1) chk("mem_addr", mem_addr, t.a);
      if (c == 1 && wren_exp) chk("mem_data", mem_data, t.d);
      if (c < lat) chk("ack_early", ack, 0);
      else begin
        chk("ack", ack, 2'b01 << t.r);
        chk("err", err, t.e_err);
        chk("rdata", rdata, t.e_rdata);
        chk("busy_ack", busy, 1);
        req = 2'b00;
      end
    end
    step();
    chk("ack_after", ack, 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic check_reset_state();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_data", mem_data, 0);
  endtask

  initial begin
    int k;
    logic [1:0] exp_ack [4];
    logic [15:0] exp_rd [4];
    for (int i = 0; i < 16; i++) ram[i] = 16'h0;
    v[0] = '{1'b0, 1'b1, 16'h0002, 16'hBEEF, 1'b0, 16'h0000};
    v[1] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hBEEF};
    v[2] = '{1'b1, 1'b1, 16'h0001, 16'h1234, 1'b1, 16'hBEEF};
    v[3] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000};
    v[4] = '{1'b1, 1'b1, 16'h0004, 16'h5A5A, 1'b0, 16'h0000};
    v[5] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h5A5A};
    v[6] = '{1'b1, 1'b1, 16'h0003, 16'h7777, 1'b1, 16'h5A5A};
    v[7] = '{1'b0, 1'b1, 16'h0003, 16'hCAFE, 1'b0, 16'h5A5A};
    v[8] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hCAFE};
    v[9] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hBEEF};
    rst = 1;
    step();
    step();
    check_reset_state();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_wren", mem_wren, 0);
      chk("idle_busy", busy, 0);
    end
    for (int i = 0; i < 10; i++) run(v[i]);
    rst = 1;
    step();
    check_reset_state();
    rst = 0;
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd = '{16'hBEEF, 16'h5A5A, 16'hBEEF, 16'h5A5A};
    req = 2'b11;
    we = 2'b00;
    addr0 = 16'h0002;
    addr1 = 16'h0004;
    k = 0;
    for (int c = 1; c <= 19; c++) begin
      step();
      chk("ack_onehot", {1'b0, ack == 2'b11}, 0);
      if (ack != 0) begin
        if (k < 4) begin
          chk("rr_grant", ack, exp_ack[k]);
          chk("rr_cycle", c, 4 + 5 * k);
          chk("rr_rdata", rdata, exp_rd[k]);
        end
        k++;
      end
      if (c == 19) req = 2'b00;
    end
    chk("rr_count", k, 4);
    step();
    step();
    chk("rr_idle", busy, 0);
    req = 2'b01;
    we = 2'b00;
    addr0 = 16'h0002;
    step();
    step();
    chk("wait_busy", busy, 1);
    rst = 1;
    req = 2'b00;
    step();
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_wren", mem_wren, 0);
    chk("abort_ack", ack, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_noack", ack, 0);
      chk("abort_idle", busy, 0);
    end
    run('{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h5A5A});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
